// File: rtl/switch_allocator_pkg.sv
// Shared router constants, output FSM state encoding and small index helpers
// used by the switch allocator and its round-robin arbiter.
package router_pkg;

    localparam int NPORT = 5;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    localparam logic [NPORT-1:0] SEL_LOCAL = 5'b00001;
    localparam logic [NPORT-1:0] SEL_NORTH = 5'b00010;
    localparam logic [NPORT-1:0] SEL_EAST  = 5'b00100;
    localparam logic [NPORT-1:0] SEL_SOUTH = 5'b01000;
    localparam logic [NPORT-1:0] SEL_WEST  = 5'b10000;

    typedef logic [0:0] out_state_t;
    localparam out_state_t ST_IDLE   = 1'b0;
    localparam out_state_t ST_LOCKED = 1'b1;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'd4) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic logic [NPORT-1:0] idx_to_sel(input logic [2:0] i);
        case (i)
            3'd0:    return SEL_LOCAL;
            3'd1:    return SEL_NORTH;
            3'd2:    return SEL_EAST;
            3'd3:    return SEL_SOUTH;
            3'd4:    return SEL_WEST;
            default: return '0;
        endcase
    endfunction

    function automatic logic [2:0] sel_to_idx(input logic [NPORT-1:0] s);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (s[k]) r = 3'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/route inputs and registered crossbar select outputs of the
// switch allocator, bundled for the router datapath.
interface switch_allocator_if;
    import router_pkg::*;

    logic [NPORT-1:0] req;
    logic [NPORT-1:0] head;
    logic [NPORT-1:0] tail;
    logic [NPORT-1:0] dest0;
    logic [NPORT-1:0] dest1;
    logic [NPORT-1:0] dest2;
    logic [NPORT-1:0] dest3;
    logic [NPORT-1:0] dest4;
    logic [NPORT-1:0] out_ready;
    logic [NPORT-1:0] sel0;
    logic [NPORT-1:0] sel1;
    logic [NPORT-1:0] sel2;
    logic [NPORT-1:0] sel3;
    logic [NPORT-1:0] sel4;
    logic [NPORT-1:0] out_valid;
    logic [NPORT-1:0] gnt;
    logic [NPORT-1:0] err_dest;

    modport master (
        output req, head, tail, dest0, dest1, dest2, dest3, dest4, out_ready,
        input  sel0, sel1, sel2, sel3, sel4, out_valid, gnt, err_dest
    );

    modport slave (
        input  req, head, tail, dest0, dest1, dest2, dest3, dest4, out_ready,
        output sel0, sel1, sel2, sel3, sel4, out_valid, gnt, err_dest
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational 5-way round-robin pick: first requester at or after i_ptr,
// wrapping 4 -> 0.
module rr_arbiter
    import router_pkg::*;
(
    input  logic [NPORT-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic [NPORT-1:0] o_gnt,
    output logic             o_any
);

    logic [2:0] w_idx;

    always_comb begin
        o_gnt = '0;
        o_any = 1'b0;
        w_idx = i_ptr;
        for (int k = 0; k < NPORT; k++) begin
            if (!o_any && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_any        = 1'b1;
            end
            w_idx = next_idx(w_idx);
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator driving registered one-hot crossbar
// selects. Trace output is enabled with SWITCH_ALLOCATOR_TRACE_EN.
//
// state     | meaning
// ST_IDLE   | output free; round-robin among head flits of valid requesters
// ST_LOCKED | output owned by r_owner until its tail flit is switched
module switch_allocator
    import router_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    switch_allocator_if.slave  bus
);

    logic [NPORT-1:0][NPORT-1:0] w_dest;
    logic [NPORT-1:0]            w_ok;
    logic [NPORT-1:0]            w_bad;
    logic [NPORT-1:0][NPORT-1:0] w_cand;
    logic [NPORT-1:0][NPORT-1:0] w_pick;
    logic [NPORT-1:0]            w_any;
    logic [NPORT-1:0][NPORT-1:0] w_grant;
    logic [2:0]                  w_gidx [NPORT];
    logic [NPORT-1:0]            w_gnt_in;
    logic [NPORT-1:0]            w_valid;

    out_state_t                  r_state [NPORT];
    logic [2:0]                  r_owner [NPORT];
    logic [2:0]                  r_ptr   [NPORT];
    logic [NPORT-1:0][NPORT-1:0] r_sel;
    logic [NPORT-1:0]            r_valid;
    logic [NPORT-1:0]            r_gnt;
    logic [NPORT-1:0]            r_err;

    assign w_dest[LOCAL] = bus.dest0;
    assign w_dest[NORTH] = bus.dest1;
    assign w_dest[EAST]  = bus.dest2;
    assign w_dest[SOUTH] = bus.dest3;
    assign w_dest[WEST]  = bus.dest4;

    // A malformed route excludes the input from every output, locked or not.
    for (genvar i = 0; i < NPORT; i++) begin : g_in
        assign w_bad[i] = bus.req[i] & ~$onehot(w_dest[i]);
        assign w_ok[i]  = bus.req[i] & $onehot(w_dest[i]);
    end

    for (genvar j = 0; j < NPORT; j++) begin : g_out
        for (genvar i = 0; i < NPORT; i++) begin : g_cand
            assign w_cand[j][i] = w_ok[i] & bus.head[i] & w_dest[i][j];
        end

        rr_arbiter u_arb (
            .i_req (w_cand[j]),
            .i_ptr (r_ptr[j]),
            .o_gnt (w_pick[j]),
            .o_any (w_any[j])
        );
    end

    always_comb begin
        w_gnt_in = '0;
        w_valid  = '0;
        for (int j = 0; j < NPORT; j++) begin
            w_grant[j] = '0;
            w_gidx[j]  = r_owner[j];
            if (r_state[j] == ST_IDLE) begin
                w_gidx[j] = sel_to_idx(w_pick[j]);
                if (bus.out_ready[j] && w_any[j]) w_grant[j] = w_pick[j];
            end else if (bus.out_ready[j] && w_ok[r_owner[j]] && w_dest[r_owner[j]][j]) begin
                w_grant[j] = idx_to_sel(r_owner[j]);
            end
            w_gnt_in   = w_gnt_in | w_grant[j];
            w_valid[j] = |w_grant[j];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NPORT; j++) begin
                r_state[j] <= ST_IDLE;
                r_owner[j] <= '0;
                r_ptr[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < NPORT; j++) begin
                if (|w_grant[j]) begin
                    if (r_state[j] == ST_IDLE) begin
                        r_ptr[j] <= next_idx(w_gidx[j]);
                        if (!bus.tail[w_gidx[j]]) begin
                            r_state[j] <= ST_LOCKED;
                            r_owner[j] <= w_gidx[j];
                        end
                    end else if (bus.tail[r_owner[j]]) begin
                        r_state[j] <= ST_IDLE;
                        r_ptr[j]   <= next_idx(r_owner[j]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= '0;
            r_valid <= '0;
            r_gnt   <= '0;
            r_err   <= '0;
        end else begin
            r_sel   <= w_grant;
            r_valid <= w_valid;
            r_gnt   <= w_gnt_in;
            r_err   <= w_bad;
        end
    end

`ifdef SWITCH_ALLOCATOR_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < NPORT; j++) begin
                if (|w_grant[j]) begin
                    $display("alloc out %d in %d head %b tail %b, %t", j, w_gidx[j],
                             bus.head[w_gidx[j]], bus.tail[w_gidx[j]], $time);
                    if (r_state[j] == ST_LOCKED && bus.tail[r_owner[j]])
                        $display("release out %d, %t", j, $time);
                end
            end
        end
    end
`endif

    assign bus.sel0      = r_sel[LOCAL];
    assign bus.sel1      = r_sel[NORTH];
    assign bus.sel2      = r_sel[EAST];
    assign bus.sel3      = r_sel[SOUTH];
    assign bus.sel4      = r_sel[WEST];
    assign bus.out_valid = r_valid;
    assign bus.gnt       = r_gnt;
    assign bus.err_dest  = r_err;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed and randomized checks of switch_allocator against a behavioural
// per-output lock/pointer model.
module tb_switch_allocator;
    import router_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_allocator_if bus();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_lock [5];
    int         m_ptr  [5];
    logic [4:0] e_sel  [5];
    logic [4:0] e_valid, e_gnt, e_err;

    function automatic logic [4:0] get_dest(int i);
        case (i)
            0: return bus.dest0;
            1: return bus.dest1;
            2: return bus.dest2;
            3: return bus.dest3;
            default: return bus.dest4;
        endcase
    endfunction

    task automatic set_dest(int i, logic [4:0] v);
        case (i)
            0: bus.dest0 = v;
            1: bus.dest1 = v;
            2: bus.dest2 = v;
            3: bus.dest3 = v;
            default: bus.dest4 = v;
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        bus.req = '0;
        bus.head = '0;
        bus.tail = '0;
        for (int i = 0; i < 5; i++) set_dest(i, 5'b0);
        bus.out_ready = 5'b11111;
    endtask

    task automatic model_reset();
        for (int j = 0; j < 5; j++) begin
            m_lock[j] = -1;
            m_ptr[j]  = 0;
            e_sel[j]  = '0;
        end
        e_valid = '0;
        e_gnt   = '0;
        e_err   = '0;
    endtask

    // Next registered outputs from current inputs; each output either follows
    // its owner or scans inputs starting at its pointer.
    task automatic model_step();
        logic [4:0] d [5];
        bit         bad [5];
        int         win;
        e_gnt = '0;
        e_valid = '0;
        e_err = '0;
        for (int i = 0; i < 5; i++) begin
            d[i]   = get_dest(i);
            bad[i] = bus.req[i] && ($countones(d[i]) != 1);
            e_err[i] = bad[i];
        end
        for (int j = 0; j < 5; j++) begin
            e_sel[j] = '0;
            if (bus.out_ready[j]) begin
                if (m_lock[j] < 0) begin
                    win = -1;
                    for (int k = 0; k < 5 && win < 0; k++) begin
                        int i;
                        i = (m_ptr[j] + k) % 5;
                        if (bus.req[i] && bus.head[i] && !bad[i] && d[i][j]) win = i;
                    end
                    if (win >= 0) begin
                        e_sel[j] = 5'(1 << win);
                        m_ptr[j] = (win + 1) % 5;
                        if (!bus.tail[win]) m_lock[j] = win;
                    end
                end else begin
                    int o;
                    o = m_lock[j];
                    if (bus.req[o] && !bad[o] && d[o][j]) begin
                        e_sel[j] = 5'(1 << o);
                        if (bus.tail[o]) begin
                            m_lock[j] = -1;
                            m_ptr[j]  = (o + 1) % 5;
                        end
                    end
                end
            end
            e_gnt      = e_gnt | e_sel[j];
            e_valid[j] = (e_sel[j] != 0);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_sel"}, {7'b0, bus.sel4, bus.sel3, bus.sel2, bus.sel1, bus.sel0},
            {7'b0, e_sel[4], e_sel[3], e_sel[2], e_sel[1], e_sel[0]});
        chk({tag, "_valid"}, {27'b0, bus.out_valid}, {27'b0, e_valid});
        chk({tag, "_gnt"}, {27'b0, bus.gnt}, {27'b0, e_gnt});
        chk({tag, "_err"}, {27'b0, bus.err_dest}, {27'b0, e_err});
    endtask

    task automatic cyc(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] rr_exp [4];
        logic [4:0] r;
        rr_exp = '{5'b00010, 5'b01000, 5'b10000, 5'b00010};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        rst = 1'b0;

        // single-flit packet input 0 -> output 2
        bus.req = 5'b00001; bus.head = 5'b00001; bus.tail = 5'b00001;
        set_dest(0, 5'b00100);
        cyc("sf");
        chk("sf_sel2", {27'b0, bus.sel2}, 32'b00001);
        chk("sf_valid", {27'b0, bus.out_valid}, 32'b00100);
        clear_inputs();
        cyc("sf_after");
        chk("sf_after_sel2", {27'b0, bus.sel2}, 32'b0);

        // round-robin among inputs 1,3,4 on output 0
        bus.req = 5'b11010; bus.head = 5'b11010; bus.tail = 5'b11010;
        set_dest(1, 5'b00001); set_dest(3, 5'b00001); set_dest(4, 5'b00001);
        for (int n = 0; n < 4; n++) begin
            cyc("rr");
            chk("rr_sel0", {27'b0, bus.sel0}, {27'b0, rr_exp[n]});
        end
        clear_inputs();
        cyc("rr_idle");

        // wormhole: input 2 three flits to output 4, input 0 head waits
        bus.req = 5'b00100; bus.head = 5'b00100; set_dest(2, 5'b10000);
        cyc("wh_head");
        chk("wh_sel4_0", {27'b0, bus.sel4}, 32'b00100);
        bus.req = 5'b00101; bus.head = 5'b00001; bus.tail = 5'b00001;
        set_dest(0, 5'b10000);
        cyc("wh_body");
        chk("wh_sel4_1", {27'b0, bus.sel4}, 32'b00100);
        bus.tail = 5'b00101;
        cyc("wh_tail");
        chk("wh_sel4_2", {27'b0, bus.sel4}, 32'b00100);
        bus.req = 5'b00001; bus.head = 5'b00001; bus.tail = 5'b00001;
        cyc("wh_next");
        chk("wh_sel4_3", {27'b0, bus.sel4}, 32'b00001);
        clear_inputs();
        cyc("wh_idle");

        // backpressure on output 1 during a locked packet from input 3
        bus.req = 5'b01000; bus.head = 5'b01000; set_dest(3, 5'b00010);
        cyc("bp_head");
        bus.head = 5'b0;
        bus.out_ready = 5'b11101;
        for (int n = 0; n < 4; n++) begin
            cyc("bp_stall");
            chk("bp_stall_sel1", {27'b0, bus.sel1}, 32'b0);
            chk("bp_stall_gnt", {27'b0, bus.gnt}, 32'b0);
        end
        bus.out_ready = 5'b11111;
        cyc("bp_body");
        chk("bp_body_sel1", {27'b0, bus.sel1}, 32'b01000);
        bus.tail = 5'b01000;
        cyc("bp_tail");
        chk("bp_tail_sel1", {27'b0, bus.sel1}, 32'b01000);
        clear_inputs();
        cyc("bp_idle");

        // bad destination on input 3, input 0 unaffected
        bus.req = 5'b01001; bus.head = 5'b01001; bus.tail = 5'b01001;
        set_dest(3, 5'b00110); set_dest(0, 5'b00100);
        for (int n = 0; n < 2; n++) begin
            cyc("bad");
            chk("bad_err", {27'b0, bus.err_dest}, 32'b01000);
            chk("bad_gnt", {27'b0, bus.gnt}, 32'b00001);
        end
        clear_inputs();
        cyc("bad_idle");

        // reset mid-packet drops the lock on output 3
        bus.req = 5'b00010; bus.head = 5'b00010; set_dest(1, 5'b01000);
        cyc("mr_head");
        async_reset("mr_async");
        bus.req = 5'b10010; bus.head = 5'b10000; bus.tail = 5'b10000;
        set_dest(4, 5'b01000);
        cyc("mr_after");
        chk("mr_sel3", {27'b0, bus.sel3}, 32'b10000);
        clear_inputs();
        cyc("mr_idle");

        for (int n = 0; n < 400; n++) begin
            if (n % 97 == 50) begin
                async_reset("rnd_async");
            end else begin
                bus.req  = 5'($urandom_range(0, 31));
                bus.head = 5'($urandom_range(0, 31));
                bus.tail = 5'($urandom_range(0, 31));
                for (int i = 0; i < 5; i++) begin
                    if ($urandom_range(0, 7) == 0) r = 5'($urandom_range(0, 31));
                    else r = 5'(1 << $urandom_range(0, 4));
                    set_dest(i, r);
                end
                for (int j = 0; j < 5; j++) bus.out_ready[j] = ($urandom_range(0, 4) != 0);
                cyc("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
